// File: rtl/fir_coef_loader_if.sv
// fir_coef_loader_if
//   Bundles every handshake and bus signal of the FIR coefficient loader:
//   load control (load_req/load_bank/load_busy/load_done/load_err),
//   coefficient memory read port (coef_rd_en/coef_rd_addr/coef_rd_data),
//   FIR config write port (cfg_valid/cfg_addr/cfg_data/cfg_busy),
//   upstream sample stream (up_din_valid/up_din_data/up_din_busy) and
//   FIR sample stream (fir_din_valid/fir_din_data/fir_din_busy).
//   master : the loader itself.
//   slave  : the environment (memory, FIR, upstream source, controller).
interface fir_coef_loader_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 6,
  parameter int BWIDTH = 2
);
  logic                      load_req;
  logic [BWIDTH-1:0]         load_bank;
  logic                      load_busy;
  logic                      load_done;
  logic                      load_err;
  logic                      coef_rd_en;
  logic [BWIDTH+AWIDTH-1:0]  coef_rd_addr;
  logic [DWIDTH-1:0]         coef_rd_data;
  logic                      cfg_valid;
  logic [AWIDTH-1:0]         cfg_addr;
  logic [DWIDTH-1:0]         cfg_data;
  logic                      cfg_busy;
  logic                      up_din_valid;
  logic [DWIDTH-1:0]         up_din_data;
  logic                      up_din_busy;
  logic                      fir_din_valid;
  logic [DWIDTH-1:0]         fir_din_data;
  logic                      fir_din_busy;

  modport master (
    input  load_req, load_bank, coef_rd_data, cfg_busy,
           up_din_valid, up_din_data, fir_din_busy,
    output load_busy, load_done, load_err, coef_rd_en, coef_rd_addr,
           cfg_valid, cfg_addr, cfg_data, up_din_busy,
           fir_din_valid, fir_din_data
  );

  modport slave (
    output load_req, load_bank, coef_rd_data, cfg_busy,
           up_din_valid, up_din_data, fir_din_busy,
    input  load_busy, load_done, load_err, coef_rd_en, coef_rd_addr,
           cfg_valid, cfg_addr, cfg_data, up_din_busy,
           fir_din_valid, fir_din_data
  );
endinterface

// File: rtl/fir_coef_loader.sv
// fir_coef_loader
//   Loads one bank of WINLEN coefficients from a coefficient memory into a
//   FIR filter's config port. While idle the sample stream passes straight
//   through to the FIR; during a load the stream is frozen, the loader waits
//   for the FIR pipeline to drain (bounded by TIMEOUT cycles), then copies
//   each coefficient with a fetch / capture / write sequence.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - fir_coef_loader_if master modport (load control, memory read,
//           config write, upstream and FIR sample streams)
module fir_coef_loader #(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 6,
  parameter int WINLEN  = 64,
  parameter int BWIDTH  = 2,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  fir_coef_loader_if.master bus
);

  localparam int CWIDTH = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    FETCH   = 3'd2,
    CAPTURE = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state_reg, state_next;
  logic [BWIDTH-1:0]   bank_reg, bank_next;
  logic [AWIDTH-1:0]   index_reg, index_next;
  logic [CWIDTH-1:0]   drain_cnt_reg, drain_cnt_next;
  logic                cfg_valid_reg, cfg_valid_next;
  logic [AWIDTH-1:0]   cfg_addr_reg, cfg_addr_next;
  logic [DWIDTH-1:0]   cfg_data_reg, cfg_data_next;

  logic                load_done;
  logic                load_err;
  logic                coef_rd_en;
  logic [BWIDTH+AWIDTH-1:0] coef_rd_addr;
  logic                idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bank_reg      <= '0;
      index_reg     <= '0;
      drain_cnt_reg <= '0;
      cfg_valid_reg <= 1'b0;
      cfg_addr_reg  <= '0;
      cfg_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      bank_reg      <= bank_next;
      index_reg     <= index_next;
      drain_cnt_reg <= drain_cnt_next;
      cfg_valid_reg <= cfg_valid_next;
      cfg_addr_reg  <= cfg_addr_next;
      cfg_data_reg  <= cfg_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bank_next      = bank_reg;
    index_next     = index_reg;
    drain_cnt_next = drain_cnt_reg;
    cfg_valid_next = cfg_valid_reg;
    cfg_addr_next  = cfg_addr_reg;
    cfg_data_next  = cfg_data_reg;
    load_done      = 1'b0;
    load_err       = 1'b0;
    coef_rd_en     = 1'b0;
    coef_rd_addr   = '0;

    case (state_reg)
      IDLE: begin
        if (bus.load_req) begin
          bank_next      = bus.load_bank;
          index_next     = '0;
          drain_cnt_next = '0;
          state_next     = DRAIN;
        end
      end
      DRAIN: begin
        // Abort on the last allowed cycle so the wait never exceeds TIMEOUT.
        if (!bus.cfg_busy) begin
          state_next = FETCH;
        end else if (drain_cnt_reg == CWIDTH'(TIMEOUT - 1)) begin
          load_err   = 1'b1;
          state_next = IDLE;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end
      FETCH: begin
        coef_rd_en   = 1'b1;
        coef_rd_addr = {bank_reg, index_reg};
        state_next   = CAPTURE;
      end
      CAPTURE: begin
        // Memory returns data one cycle after the strobe, i.e. now.
        cfg_data_next  = bus.coef_rd_data;
        cfg_addr_next  = index_reg;
        cfg_valid_next = 1'b1;
        state_next     = WRITE;
      end
      WRITE: begin
        if (!bus.cfg_busy) begin
          cfg_valid_next = 1'b0;
          if (index_reg == AWIDTH'(WINLEN - 1)) begin
            state_next = DONE;
          end else begin
            index_next = index_reg + 1'b1;
            state_next = FETCH;
          end
        end
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign idle = (state_reg == IDLE);

  assign bus.load_busy     = !idle;
  assign bus.load_done     = load_done;
  assign bus.load_err      = load_err;
  assign bus.coef_rd_en    = coef_rd_en;
  assign bus.coef_rd_addr  = coef_rd_addr;
  assign bus.cfg_valid     = cfg_valid_reg;
  assign bus.cfg_addr      = cfg_addr_reg;
  assign bus.cfg_data      = cfg_data_reg;

  // Stream is a pure combinational pass-through when idle, frozen otherwise.
  assign bus.fir_din_valid = idle && bus.up_din_valid;
  assign bus.fir_din_data  = bus.up_din_data;
  assign bus.up_din_busy   = idle ? bus.fir_din_busy : 1'b1;

endmodule

// File: tb/tb_fir_coef_loader.sv
module tb_fir_coef_loader;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int BW = 2;
  localparam int WL = 64;
  localparam int TO = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_coef_loader_if #(.DWIDTH(DW), .AWIDTH(AW), .BWIDTH(BW)) bus ();

  fir_coef_loader #(
    .DWIDTH(DW), .AWIDTH(AW), .WINLEN(WL), .BWIDTH(BW), .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Coefficient memory model: word = low 8 bits of address, one-cycle latency.
  always @(posedge clk)
    bus.coef_rd_data <= bus.coef_rd_en ? bus.coef_rd_addr[7:0] : 8'hEE;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int addr; int data; } wr_t;
  wr_t wr_q[$];
  int  st_q[$];

  int done_cnt = 0, done_cyc = -1;
  int err_cnt = 0, err_cyc = -1;
  int rd_cnt = 0, first_rd_cyc = -1;
  int hold_cnt = 0;
  logic hold_prev = 1'b0;
  int hold_addr = 0, hold_data = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input int act, input int exp);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev) begin
        check("hold_valid", int'(bus.cfg_valid), 1);
        check("hold_addr", int'(bus.cfg_addr), hold_addr);
        check("hold_data", int'(bus.cfg_data), hold_data);
      end
      hold_prev = bus.cfg_valid && bus.cfg_busy;
      if (hold_prev) hold_cnt++;
      hold_addr = int'(bus.cfg_addr);
      hold_data = int'(bus.cfg_data);

      if (bus.cfg_valid && !bus.cfg_busy) begin
        if (wr_q.size() == 0) flag("unexpected_cfg_write", int'(bus.cfg_addr), -1);
        else begin
          wr_t e;
          e = wr_q.pop_front();
          check("cfg_addr", int'(bus.cfg_addr), e.addr);
          check("cfg_data", int'(bus.cfg_data), e.data);
          $display("cfg write addr=%0d data=0x%02h", bus.cfg_addr, bus.cfg_data);
        end
      end

      if (bus.fir_din_valid && !bus.fir_din_busy) begin
        if (st_q.size() == 0) flag("unexpected_sample", int'(bus.fir_din_data), -1);
        else begin
          int s;
          s = st_q.pop_front();
          check("stream_data", int'(bus.fir_din_data), s);
          $display("stream sample %0d", bus.fir_din_data);
        end
      end

      if (bus.load_busy) begin
        if (bus.fir_din_valid || !bus.up_din_busy)
          flag("stream_not_gated", int'(bus.fir_din_valid), 0);
      end else begin
        if (bus.up_din_busy !== bus.fir_din_busy)
          flag("passthru_busy", int'(bus.up_din_busy), int'(bus.fir_din_busy));
        if (bus.fir_din_valid !== bus.up_din_valid)
          flag("passthru_valid", int'(bus.fir_din_valid), int'(bus.up_din_valid));
        if (bus.cfg_valid || bus.coef_rd_en)
          flag("idle_strobe", int'(bus.cfg_valid), 0);
      end

      if (bus.load_done && bus.load_err) flag("done_and_err", 1, 0);
      if (bus.load_done) begin done_cnt++; done_cyc = cyc; end
      if (bus.load_err)  begin err_cnt++;  err_cyc = cyc;  end
      if (bus.coef_rd_en) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bank(input int bank);
    for (int i = 0; i < WL; i++) wr_q.push_back('{i, (bank * WL + i) & 255});
  endtask

  task automatic start_load(input int bank, output int acc);
    done_cnt = 0; err_cnt = 0; rd_cnt = 0; first_rd_cyc = -1;
    bus.load_req  = 1'b1;
    bus.load_bank = BW'(bank);
    acc = cyc;
    tick();
    bus.load_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int acc, input int exp_lat);
    int k = 0;
    while (done_cnt == 0 && k < 600) begin tick(); k++; end
    check({name, "_done_seen"}, done_cnt, 1);
    check({name, "_done_latency"}, done_cyc - acc, exp_lat);
    tick();
    check({name, "_done_pulse"}, done_cnt, 1);
    check({name, "_idle_after"}, int'(bus.load_busy), 0);
    check({name, "_writes_left"}, wr_q.size(), 0);
    check({name, "_reads"}, rd_cnt, WL);
    $display("load %s done latency %0d", name, done_cyc - acc);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_load_busy"}, int'(bus.load_busy), 0);
    check({name, "_load_done"}, int'(bus.load_done), 0);
    check({name, "_load_err"}, int'(bus.load_err), 0);
    check({name, "_coef_rd_en"}, int'(bus.coef_rd_en), 0);
    check({name, "_coef_rd_addr"}, int'(bus.coef_rd_addr), 0);
    check({name, "_cfg_valid"}, int'(bus.cfg_valid), 0);
    check({name, "_cfg_addr"}, int'(bus.cfg_addr), 0);
    check({name, "_cfg_data"}, int'(bus.cfg_data), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int k;
    int s;
    int h0;
    logic accepted;

    bus.load_req = 1'b0;  bus.load_bank = '0;
    bus.cfg_busy = 1'b0;  bus.up_din_valid = 1'b0;
    bus.up_din_data = '0; bus.fir_din_busy = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Idle pass-through, samples 1..10 with FIR backpressure toggling
    for (int i = 1; i <= 10; i++) st_q.push_back(i);
    s = 1; k = 0;
    while (s <= 10 && k < 100) begin
      bus.up_din_valid = 1'b1;
      bus.up_din_data  = DW'(s);
      bus.fir_din_busy = k[0];
      @(negedge clk);
      accepted = !bus.up_din_busy;
      tick();
      if (accepted) s++;
      k++;
    end
    bus.up_din_valid = 1'b0;
    bus.fir_din_busy = 1'b0;
    tick();
    check("idle_stream_drained", st_q.size(), 0);

    // Bank 2 load, sample transferred in the acceptance cycle, stray load_req ignored
    push_bank(2);
    st_q.push_back(11);
    bus.up_din_valid = 1'b1;
    bus.up_din_data  = 8'd11;
    start_load(2, acc);
    bus.up_din_data = 8'd99;   // must stay frozen during the load
    repeat (40) tick();
    bus.load_req = 1'b1; bus.load_bank = 2'd0;
    tick();
    bus.load_req = 1'b0;
    repeat (40) tick();
    bus.up_din_valid = 1'b0;
    wait_done("bank2", acc, 194);
    check("bank2_stream_left", st_q.size(), 0);

    // Drain: cfg_busy high for 10 cycles after acceptance
    push_bank(1);
    bus.cfg_busy = 1'b1;
    start_load(1, acc);
    while (cyc < acc + 11) tick();
    bus.cfg_busy = 1'b0;
    wait_done("drain", acc, 204);
    check("drain_first_read", first_rd_cyc - acc, 12);

    // Backpressure on the write of index 5
    push_bank(3);
    h0 = hold_cnt;
    start_load(3, acc);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.coef_rd_en && bus.coef_rd_addr[5:0] == 6'd5) && k < 100);
    tick();
    bus.cfg_busy = 1'b1;
    repeat (4) tick();
    bus.cfg_busy = 1'b0;
    wait_done("bp", acc, 197);
    check("bp_hold_cycles", hold_cnt - h0, 3);

    // Drain timeout
    bus.cfg_busy = 1'b1;
    start_load(0, acc);
    k = 0;
    while (err_cnt == 0 && k < 400) begin tick(); k++; end
    bus.cfg_busy = 1'b0;
    check("timeout_err_seen", err_cnt, 1);
    check("timeout_err_latency", err_cyc - acc, 256);
    tick();
    check("timeout_err_pulse", err_cnt, 1);
    check("timeout_no_done", done_cnt, 0);
    check("timeout_no_reads", rd_cnt, 0);
    check("timeout_idle", int'(bus.load_busy), 0);
    st_q.push_back(42);
    bus.up_din_valid = 1'b1;
    bus.up_din_data  = 8'd42;
    tick();
    bus.up_din_valid = 1'b0;
    tick();
    check("timeout_passthru", st_q.size(), 0);

    // Reset in the middle of a load, then a fresh bank 1 load
    push_bank(2);
    start_load(2, acc);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.coef_rd_en && bus.coef_rd_addr[5:0] == 6'd30) && k < 200);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    check("midreset_writes_left", wr_q.size(), WL - 30);
    wr_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("midreset_no_done", done_cnt, 0);
    push_bank(1);
    start_load(1, acc);
    wait_done("after_reset", acc, 194);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
